// File: rtl/uart_alu_pkg.sv
// Shared types and defaults for the UART/ALU command controller.
package uart_alu_pkg;

  localparam int DBIT_DEF        = 8;
  localparam int NB_OP_DEF       = 6;
  localparam int TIMEOUT_CYC_DEF = 1000000;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_e;

  // Counter must hold 0..cyc-1; never narrower than one bit.
  function automatic int cnt_width(input int cyc);
    return (cyc > 2) ? $clog2(cyc) : 1;
  endfunction

  localparam int TO_CNT_W_DEF = cnt_width(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/uart_alu_intf_timeout_cnt.sv
// Inter-byte timeout counter; only present when UART_INTF_TIMEOUT_EN is defined.
`ifdef UART_INTF_TIMEOUT_EN
module intf_timeout_cnt
  import uart_alu_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)
      cnt_d = '0;
    else if (i_enable && (cnt_q != LAST))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  // A clear means a byte arrived this cycle, which always beats expiry.
  assign o_expired = i_enable && !i_clear && (cnt_q == LAST);

endmodule
`endif

// File: rtl/uart_alu_intf.sv
// Collects A, B, opcode bytes from uart_rx, runs the ALU and sends the result byte.
// Optional inter-byte timeout enabled by defining UART_INTF_TIMEOUT_EN.
module uart_alu_intf
  import uart_alu_pkg::*;
#(
  parameter int DBIT        = DBIT_DEF,
  parameter int NB_OP       = NB_OP_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_rx_done_tick,
  input  logic [DBIT-1:0]  i_rx_data,
  input  logic [DBIT-1:0]  i_alu_result,
  input  logic             i_tx_done_tick,
  output logic [DBIT-1:0]  o_alu_a,
  output logic [DBIT-1:0]  o_alu_b,
  output logic [NB_OP-1:0] o_alu_op,
  output logic             o_tx_start,
  output logic [DBIT-1:0]  o_tx_data,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_timeout
);

  state_e           state_q, state_d;
  logic [DBIT-1:0]  a_q, a_d, b_q, b_d, tx_q, tx_d;
  logic [NB_OP-1:0] op_q, op_d;
  logic             to_expired;

`ifdef UART_INTF_TIMEOUT_EN
  logic to_clear, to_enable;

  assign to_clear  = i_rx_done_tick && ((state_q == WAIT_A) || (state_q == WAIT_B));
  assign to_enable = (state_q == WAIT_B) || (state_q == WAIT_OP);

  intf_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (to_clear),
    .i_enable  (to_enable),
    .o_expired (to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_d       = tx_q;
    o_tx_start = 1'b0;
    o_busy     = 1'b0;
    o_overrun  = 1'b0;
    o_timeout  = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (i_rx_done_tick) begin
          a_d     = i_rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done_tick) begin
          b_d     = i_rx_data;
          state_d = WAIT_OP;
        end else if (to_expired) begin
          o_timeout = 1'b1;
          state_d   = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (i_rx_done_tick) begin
          op_d    = i_rx_data[NB_OP-1:0];
          state_d = EXEC;
        end else if (to_expired) begin
          o_timeout = 1'b1;
          state_d   = WAIT_A;
        end
      end
      // Busy states: incoming bytes are dropped and flagged as overrun.
      EXEC: begin
        o_busy    = 1'b1;
        o_overrun = i_rx_done_tick;
        tx_d      = i_alu_result;
        state_d   = SEND;
      end
      SEND: begin
        o_busy     = 1'b1;
        o_overrun  = i_rx_done_tick;
        o_tx_start = 1'b1;
        state_d    = WAIT_TX;
      end
      WAIT_TX: begin
        o_busy    = 1'b1;
        o_overrun = i_rx_done_tick;
        if (i_tx_done_tick) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
  end

  assign o_alu_a   = a_q;
  assign o_alu_b   = b_q;
  assign o_alu_op  = op_q;
  assign o_tx_data = tx_q;

endmodule
